// File: rtl/pipe_ctrl_unit.sv
// Control unit for the five-stage MIPS32 pipeline: it decodes the IF/ID instruction,
// carries the control bundle through ID/EX, EX/MEM and MEM/WB, and resolves hazards.
module pipe_ctrl_unit #(
    parameter int INST_W  = 32,
    parameter int ALUOP_W = 6,
    parameter int RA_W    = 5,
    parameter int FWD_EN  = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INST_W-1:0]  if_id_inst,
    input  logic               if_id_valid,
    input  logic               branch_taken,
    output logic               stall,
    output logic               flush_ifid,
    output logic               id_sign_ext,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_use_imm,
    output logic               ex_shift,
    output logic               ex_use_rt,
    output logic               ex_can_ovf,
    output logic [1:0]         ex_fwd_a,
    output logic [1:0]         ex_fwd_b,
    output logic               ex_illegal,
    output logic               mem_branch,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [RA_W-1:0]    wb_dest
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;

    // ALU encodings mirror the SPECIAL func codes, so SLL (the bubble op) is all zeros.
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(6'h20);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6'h22);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(6'h24);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(6'h25);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(6'h26);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(6'h27);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(6'h2A);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(6'h00);
    localparam logic [ALUOP_W-1:0] ALU_SRL = ALUOP_W'(6'h02);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(6'h03);

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               use_imm;
        logic               shift;
        logic               use_rt;
        logic               can_ovf;
        logic               illegal;
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_write;
        logic               branch;
        logic [RA_W-1:0]    dest;
    } ctrl_t;

    // True when a writer of a non-zero dest feeds one of the registers actually read.
    function automatic logic reads_dest(input logic use_rs, input logic use_rt,
                                        input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                                        input logic wr, input logic [RA_W-1:0] dest);
        return wr & (dest != '0) & ((use_rs & (rs == dest)) | (use_rt & (rt == dest)));
    endfunction

    logic [5:0]      opcode_s, func_s;
    logic [RA_W-1:0] rs_s, rt_s, rd_s;
    logic            unused_shamt_s;
    ctrl_t           dec_s, dec_q_s, idex_r;
    logic            sign_ext_s, illegal_s, rd_rs_s, rd_rt_s, rd_rs_q_s, rd_rt_q_s;
    logic            flush_s, stall_s, hazard_s, idex_hit_s, exmem_hit_s;
    logic [1:0]      fwd_a_nxt_s, fwd_b_nxt_s, fwd_a_r, fwd_b_r;
    logic            em_branch_r, em_mem_write_r, em_reg_write_r, em_mem_to_reg_r;
    logic [RA_W-1:0] em_dest_r;
    logic            wb_reg_write_r, wb_mem_to_reg_r;
    logic [RA_W-1:0] wb_dest_r;

    assign opcode_s       = if_id_inst[INST_W-1 -: 6];
    assign rs_s           = if_id_inst[INST_W-7 -: RA_W];
    assign rt_s           = if_id_inst[INST_W-7-RA_W -: RA_W];
    assign rd_s           = if_id_inst[INST_W-7-2*RA_W -: RA_W];
    assign func_s         = if_id_inst[5:0];
    assign unused_shamt_s = ^if_id_inst[INST_W-7-3*RA_W : 6];

    // Instruction decode of the IF/ID word.
    always_comb begin
        dec_s      = '0;
        sign_ext_s = 1'b1;
        illegal_s  = 1'b0;
        rd_rs_s    = 1'b1;
        rd_rt_s    = 1'b0;
        case (opcode_s)
            OP_SPECIAL: begin
                dec_s.dest      = rd_s;
                dec_s.reg_write = 1'b1;
                rd_rt_s         = 1'b1;
                case (func_s)
                    F_ADD: begin dec_s.alu_op = ALU_ADD; dec_s.can_ovf = 1'b1; end
                    F_SUB: begin dec_s.alu_op = ALU_SUB; dec_s.can_ovf = 1'b1; end
                    F_AND: dec_s.alu_op = ALU_AND;
                    F_OR:  dec_s.alu_op = ALU_OR;
                    F_XOR: dec_s.alu_op = ALU_XOR;
                    F_NOR: dec_s.alu_op = ALU_NOR;
                    F_SLT: dec_s.alu_op = ALU_SLT;
                    F_SLL: begin dec_s.alu_op = ALU_SLL; dec_s.shift = 1'b1; rd_rs_s = 1'b0; end
                    F_SRL: begin dec_s.alu_op = ALU_SRL; dec_s.shift = 1'b1; rd_rs_s = 1'b0; end
                    F_SRA: begin dec_s.alu_op = ALU_SRA; dec_s.shift = 1'b1; rd_rs_s = 1'b0; end
                    default: illegal_s = 1'b1;
                endcase
            end
            OP_ADDI: begin
                dec_s.alu_op  = ALU_ADD;  dec_s.use_imm = 1'b1; dec_s.can_ovf = 1'b1;
                dec_s.use_rt  = 1'b1;     dec_s.dest = rt_s;    dec_s.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec_s.alu_op  = ALU_AND;  dec_s.use_imm = 1'b1; sign_ext_s = 1'b0;
                dec_s.use_rt  = 1'b1;     dec_s.dest = rt_s;    dec_s.reg_write = 1'b1;
            end
            OP_ORI: begin
                dec_s.alu_op  = ALU_OR;   dec_s.use_imm = 1'b1; sign_ext_s = 1'b0;
                dec_s.use_rt  = 1'b1;     dec_s.dest = rt_s;    dec_s.reg_write = 1'b1;
            end
            OP_LW: begin
                dec_s.alu_op  = ALU_ADD;  dec_s.use_imm = 1'b1; dec_s.mem_to_reg = 1'b1;
                dec_s.use_rt  = 1'b1;     dec_s.dest = rt_s;    dec_s.reg_write = 1'b1;
            end
            OP_SW: begin
                dec_s.alu_op = ALU_ADD; dec_s.use_imm = 1'b1; dec_s.mem_write = 1'b1;
                rd_rt_s      = 1'b1;
            end
            OP_BEQ: begin
                dec_s.alu_op = ALU_SUB; dec_s.branch = 1'b1; rd_rt_s = 1'b1;
            end
            default: illegal_s = 1'b1;
        endcase
        if (illegal_s) begin
            dec_s         = '0;
            dec_s.illegal = 1'b1;
            dec_s.alu_op  = ALU_SLL;
            rd_rs_s       = 1'b0;
            rd_rt_s       = 1'b0;
        end else begin
            dec_s.illegal = 1'b0;
        end
        dec_s.reg_write = dec_s.reg_write & (dec_s.dest != '0);
    end

    assign dec_q_s   = if_id_valid ? dec_s : '0;
    assign rd_rs_q_s = rd_rs_s & if_id_valid;
    assign rd_rt_q_s = rd_rt_s & if_id_valid;

    // Hazard detection, stall/flush arbitration and forwarding selects for the next EX entry.
    always_comb begin
        flush_s     = em_branch_r & branch_taken;
        idex_hit_s  = reads_dest(rd_rs_q_s, rd_rt_q_s, rs_s, rt_s, idex_r.reg_write, idex_r.dest);
        exmem_hit_s = reads_dest(rd_rs_q_s, rd_rt_q_s, rs_s, rt_s, em_reg_write_r, em_dest_r);
        fwd_a_nxt_s = 2'b00;
        fwd_b_nxt_s = 2'b00;
        if (FWD_EN != 0) begin
            hazard_s = idex_hit_s & idex_r.mem_to_reg;
            // Today's ID/EX becomes tomorrow's EX/MEM, today's EX/MEM tomorrow's MEM/WB.
            if (reads_dest(rd_rs_q_s, 1'b0, rs_s, rt_s, idex_r.reg_write, idex_r.dest)) begin
                fwd_a_nxt_s = 2'b01;
            end else if (reads_dest(rd_rs_q_s, 1'b0, rs_s, rt_s, em_reg_write_r, em_dest_r)) begin
                fwd_a_nxt_s = 2'b10;
            end else begin
                fwd_a_nxt_s = 2'b00;
            end
            if (reads_dest(1'b0, rd_rt_q_s, rs_s, rt_s, idex_r.reg_write, idex_r.dest)) begin
                fwd_b_nxt_s = 2'b01;
            end else if (reads_dest(1'b0, rd_rt_q_s, rs_s, rt_s, em_reg_write_r, em_dest_r)) begin
                fwd_b_nxt_s = 2'b10;
            end else begin
                fwd_b_nxt_s = 2'b00;
            end
        end else begin
            hazard_s = idex_hit_s | exmem_hit_s;
        end
        stall_s = hazard_s & ~flush_s;
    end

    // Pipeline control registers: ID/EX, EX/MEM, MEM/WB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idex_r           <= '0;
            fwd_a_r          <= 2'b00;
            fwd_b_r          <= 2'b00;
            em_branch_r      <= 1'b0;
            em_mem_write_r   <= 1'b0;
            em_reg_write_r   <= 1'b0;
            em_mem_to_reg_r  <= 1'b0;
            em_dest_r        <= '0;
            wb_reg_write_r   <= 1'b0;
            wb_mem_to_reg_r  <= 1'b0;
            wb_dest_r        <= '0;
        end else begin
            wb_reg_write_r  <= em_reg_write_r;
            wb_mem_to_reg_r <= em_mem_to_reg_r;
            wb_dest_r       <= em_dest_r;
            if (flush_s) begin
                em_branch_r     <= 1'b0;
                em_mem_write_r  <= 1'b0;
                em_reg_write_r  <= 1'b0;
                em_mem_to_reg_r <= 1'b0;
                em_dest_r       <= '0;
            end else begin
                em_branch_r     <= idex_r.branch;
                em_mem_write_r  <= idex_r.mem_write;
                em_reg_write_r  <= idex_r.reg_write;
                em_mem_to_reg_r <= idex_r.mem_to_reg;
                em_dest_r       <= idex_r.dest;
            end
            if (flush_s || stall_s) begin
                idex_r  <= '0;
                fwd_a_r <= 2'b00;
                fwd_b_r <= 2'b00;
            end else begin
                idex_r  <= dec_q_s;
                fwd_a_r <= fwd_a_nxt_s;
                fwd_b_r <= fwd_b_nxt_s;
            end
        end
    end

    assign stall         = stall_s;
    assign flush_ifid    = flush_s;
    assign id_sign_ext   = sign_ext_s & if_id_valid & ~reset;
    assign ex_alu_op     = idex_r.alu_op;
    assign ex_use_imm    = idex_r.use_imm;
    assign ex_shift      = idex_r.shift;
    assign ex_use_rt     = idex_r.use_rt;
    assign ex_can_ovf    = idex_r.can_ovf;
    assign ex_illegal    = idex_r.illegal;
    assign ex_fwd_a      = fwd_a_r;
    assign ex_fwd_b      = fwd_b_r;
    assign mem_branch    = em_branch_r;
    assign mem_write     = em_mem_write_r;
    assign wb_reg_write  = wb_reg_write_r;
    assign wb_mem_to_reg = wb_mem_to_reg_r;
    assign wb_dest       = wb_dest_r;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a decode vector table plus hand-written hazard,
// branch-flush and reset sequences. dut uses forwarding, dut0 runs without it.
module tb_pipe_ctrl_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inst, inst0;
    logic        valid, valid0, taken, taken0;

    logic       stall, flush_ifid, id_sign_ext, ex_use_imm, ex_shift, ex_use_rt, ex_can_ovf;
    logic [5:0] ex_alu_op;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic       ex_illegal, mem_branch, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dest;

    logic       stall_0, flush_ifid_0, id_sign_ext_0, ex_use_imm_0, ex_shift_0, ex_use_rt_0, ex_can_ovf_0;
    logic [5:0] ex_alu_op_0;
    logic [1:0] ex_fwd_a_0, ex_fwd_b_0;
    logic       ex_illegal_0, mem_branch_0, mem_write_0, wb_reg_write_0, wb_mem_to_reg_0;
    logic [4:0] wb_dest_0;

    logic [31:0] outs_all, outs_all_0;
    int n_cmp = 0;
    int n_err = 0;
    int cnt;

    typedef struct {
        logic [31:0] inst;
        logic        valid;
        logic        sext;
        logic [5:0]  alu;
        logic        imm, shift, use_rt, ovf, ill, mw, br, rw, m2r;
        logic [4:0]  dest;
    } vec_t;
    vec_t vecs[20];

    always #5 clock = ~clock;

    pipe_ctrl_unit #(.FWD_EN(1)) dut (
        .clock(clock), .reset(reset), .if_id_inst(inst), .if_id_valid(valid),
        .branch_taken(taken), .stall(stall), .flush_ifid(flush_ifid),
        .id_sign_ext(id_sign_ext), .ex_alu_op(ex_alu_op), .ex_use_imm(ex_use_imm),
        .ex_shift(ex_shift), .ex_use_rt(ex_use_rt), .ex_can_ovf(ex_can_ovf),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .ex_illegal(ex_illegal),
        .mem_branch(mem_branch), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest));

    pipe_ctrl_unit #(.FWD_EN(0)) dut0 (
        .clock(clock), .reset(reset), .if_id_inst(inst0), .if_id_valid(valid0),
        .branch_taken(taken0), .stall(stall_0), .flush_ifid(flush_ifid_0),
        .id_sign_ext(id_sign_ext_0), .ex_alu_op(ex_alu_op_0), .ex_use_imm(ex_use_imm_0),
        .ex_shift(ex_shift_0), .ex_use_rt(ex_use_rt_0), .ex_can_ovf(ex_can_ovf_0),
        .ex_fwd_a(ex_fwd_a_0), .ex_fwd_b(ex_fwd_b_0), .ex_illegal(ex_illegal_0),
        .mem_branch(mem_branch_0), .mem_write(mem_write_0), .wb_reg_write(wb_reg_write_0),
        .wb_mem_to_reg(wb_mem_to_reg_0), .wb_dest(wb_dest_0));

    assign outs_all = {5'd0, stall, flush_ifid, id_sign_ext, ex_alu_op, ex_use_imm, ex_shift,
                       ex_use_rt, ex_can_ovf, ex_fwd_a, ex_fwd_b, ex_illegal, mem_branch,
                       mem_write, wb_reg_write, wb_mem_to_reg, wb_dest};
    assign outs_all_0 = {5'd0, stall_0, flush_ifid_0, id_sign_ext_0, ex_alu_op_0, ex_use_imm_0,
                         ex_shift_0, ex_use_rt_0, ex_can_ovf_0, ex_fwd_a_0, ex_fwd_b_0,
                         ex_illegal_0, mem_branch_0, mem_write_0, wb_reg_write_0,
                         wb_mem_to_reg_0, wb_dest_0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        valid = 1'b0;
        valid0 = 1'b0;
        taken = 1'b0;
        taken0 = 1'b0;
        repeat (4) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            inst          v     sx    alu    imm   sh    rt    ovf   ill   mw    br    rw    m2r   dest
        vecs[0]  = '{32'h20050007, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5};
        vecs[1]  = '{32'h00221820, 1'b1, 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3};
        vecs[2]  = '{32'h00E83022, 1'b1, 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6};
        vecs[3]  = '{32'h00224824, 1'b1, 1'b1, 6'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9};
        vecs[4]  = '{32'h00225025, 1'b1, 1'b1, 6'h25, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd10};
        vecs[5]  = '{32'h00225826, 1'b1, 1'b1, 6'h26, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd11};
        vecs[6]  = '{32'h00226027, 1'b1, 1'b1, 6'h27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd12};
        vecs[7]  = '{32'h0022682A, 1'b1, 1'b1, 6'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd13};
        vecs[8]  = '{32'h00027100, 1'b1, 1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14};
        vecs[9]  = '{32'h00027842, 1'b1, 1'b1, 6'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd15};
        vecs[10] = '{32'h000280C3, 1'b1, 1'b1, 6'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16};
        vecs[11] = '{32'h303100FF, 1'b1, 1'b0, 6'h24, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd17};
        vecs[12] = '{32'h34320001, 1'b1, 1'b0, 6'h25, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd18};
        vecs[13] = '{32'h8C220000, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2};
        vecs[14] = '{32'hAC220004, 1'b1, 1'b1, 6'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[15] = '{32'h10210004, 1'b1, 1'b1, 6'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
        vecs[16] = '{32'hFC000000, 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[17] = '{32'h00221801, 1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[18] = '{32'h00220020, 1'b1, 1'b1, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
        vecs[19] = '{32'h00221820, 1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

        // Reset with a live instruction presented: every output stays low.
        reset = 1'b1; inst = 32'h20050007; valid = 1'b1; taken = 1'b0;
        inst0 = 32'h20050007; valid0 = 1'b1; taken0 = 1'b0;
        cyc(); cyc();
        chk("reset_outs", outs_all, 32'd0);
        chk("reset_outs_nofwd", outs_all_0, 32'd0);
        reset = 1'b0;
        drain();

        // Decode table: each entry issued alone, checked at EX, MEM and WB latency.
        for (int i = 0; i < 20; i++) begin
            inst = vecs[i].inst; valid = vecs[i].valid;
            #1;
            chk($sformatf("v%0d_sext", i), 32'(id_sign_ext), 32'(vecs[i].sext));
            cyc();
            valid = 1'b0;
            chk($sformatf("v%0d_alu", i), 32'(ex_alu_op), 32'(vecs[i].alu));
            chk($sformatf("v%0d_ex", i), {27'd0, ex_use_imm, ex_shift, ex_use_rt, ex_can_ovf, ex_illegal},
                {27'd0, vecs[i].imm, vecs[i].shift, vecs[i].use_rt, vecs[i].ovf, vecs[i].ill});
            chk($sformatf("v%0d_fwd", i), {28'd0, ex_fwd_a, ex_fwd_b}, 32'd0);
            cyc();
            chk($sformatf("v%0d_mem", i), {30'd0, mem_write, mem_branch}, {30'd0, vecs[i].mw, vecs[i].br});
            cyc();
            chk($sformatf("v%0d_wb", i), {25'd0, wb_reg_write, wb_mem_to_reg, wb_dest},
                {25'd0, vecs[i].rw, vecs[i].m2r, vecs[i].dest});
        end
        drain();

        // Back-to-back RAW with forwarding: EX/MEM forward on both operands, no stall.
        inst = 32'h00221820; valid = 1'b1;
        cyc();
        inst = 32'h00632020;
        #1;
        chk("raw_fwd_stall", 32'(stall), 32'd0);
        cyc();
        chk("raw_fwd_sel", {28'd0, ex_fwd_a, ex_fwd_b}, {28'd0, 2'b01, 2'b01});
        chk("raw_fwd_ovf", 32'(ex_can_ovf), 32'd1);
        drain();

        // Same pair without forwarding: two stall cycles, then plain regfile operands.
        inst0 = 32'h00221820; valid0 = 1'b1;
        cyc();
        inst0 = 32'h00632020;
        #1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (stall_0) cnt++;
            cyc();
        end
        chk("raw_nofwd_stall_cycles", 32'(cnt), 32'd2);
        chk("raw_nofwd_sel", {28'd0, ex_fwd_a_0, ex_fwd_b_0}, 32'd0);
        chk("raw_nofwd_issue", 32'(ex_alu_op_0), 32'h20);
        drain();

        // Load-use: exactly one stall, one bubble, then MEM/WB forwarding.
        inst = 32'h8C220000; valid = 1'b1;
        cyc();
        inst = 32'h00422020;
        #1;
        chk("lu_stall_1", 32'(stall), 32'd1);
        cyc();
        chk("lu_stall_2", 32'(stall), 32'd0);
        chk("lu_bubble", {25'd0, ex_alu_op, ex_use_imm}, 32'd0);
        cyc();
        chk("lu_fwd_sel", {28'd0, ex_fwd_a, ex_fwd_b}, {28'd0, 2'b10, 2'b10});
        chk("lu_issue", 32'(ex_alu_op), 32'h20);
        drain();

        // Taken branch squashes a younger SW.
        inst = 32'h10210004; valid = 1'b1;
        cyc();
        inst = 32'hAC220004;
        cyc();
        inst = 32'h00A53020; taken = 1'b1;
        #1;
        chk("br_sw_flush", {29'd0, flush_ifid, mem_branch, stall}, {29'd0, 1'b1, 1'b1, 1'b0});
        cyc();
        valid = 1'b0; taken = 1'b0;
        chk("br_sw_slot1", {29'd0, mem_write, wb_reg_write, ex_illegal}, 32'd0);
        chk("br_sw_ex_bubble", 32'(ex_alu_op), 32'd0);
        cyc();
        chk("br_sw_slot2", {30'd0, mem_write, wb_reg_write}, 32'd0);
        drain();

        // Taken branch coinciding with a load-use hazard: flush wins, LW never writes back.
        inst = 32'h10210004; valid = 1'b1;
        cyc();
        inst = 32'h8C250000;
        cyc();
        inst = 32'h00A53020;
        #1;
        chk("br_lu_stall_alone", 32'(stall), 32'd1);
        taken = 1'b1;
        #1;
        chk("br_lu_flush", {30'd0, flush_ifid, stall}, {30'd0, 1'b1, 1'b0});
        cyc();
        valid = 1'b0; taken = 1'b0;
        chk("br_lu_slot1", {27'd0, wb_reg_write, ex_alu_op[3:0]}, 32'd0);
        cyc();
        chk("br_lu_slot2", {26'd0, wb_reg_write, wb_dest}, 32'd0);
        drain();

        // Reset mid-stream with three entries in flight.
        inst = 32'h20050007; valid = 1'b1;
        cyc();
        inst = 32'h20060001;
        cyc();
        inst = 32'h20070002;
        cyc();
        chk("mid_pre_wb", {26'd0, wb_reg_write, wb_dest}, {26'd0, 1'b1, 5'd5});
        reset = 1'b1; inst = 32'h20080003;
        #1;
        chk("mid_reset_outs", outs_all, 32'd0);
        cyc();
        chk("mid_reset_outs_edge", outs_all, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_bubble_1", 32'(wb_reg_write), 32'd0);
        cyc();
        valid = 1'b0;
        chk("mid_bubble_2", 32'(wb_reg_write), 32'd0);
        chk("mid_ex_new", 32'(ex_use_imm), 32'd1);
        cyc();
        chk("mid_bubble_3", 32'(wb_reg_write), 32'd0);
        cyc();
        chk("mid_first_result", {26'd0, wb_reg_write, wb_dest}, {26'd0, 1'b1, 5'd8});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised pipelined control unit for the five-stage MIPS32 CPU.
- Decodes the IF/ID instruction once and carries the control bundle through its own ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use and RAW hazards, generates operand-forwarding selects, and applies stall/flush for taken branches.
- Sits beside the datapath pipeline registers and drives all stage-local control signals.

Parameters:
- INST_W, 32: instruction width; opcode is [INST_W-1:INST_W-6], func is [5:0].
- ALUOP_W, 6: ALU operation code width; encodings come from the shared ALUOP include.
- RA_W, 5: register address width.
- FWD_EN, 1: 1 = forwarding with load-use stall only; 0 = no forwarding, stall on any RAW hazard.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_id_inst  in  INST_W  instruction held in the IF/ID register.
- if_id_valid  in  1  IF/ID holds a real instruction.
- branch_taken  in  1  BEQ compare result, valid while mem_branch=1.
- stall  out  1  hold PC and IF/ID this cycle.
- flush_ifid  out  1  clear IF/ID at next edge.
- id_sign_ext  out  1  sign-extend the immediate of the IF/ID instruction.
- ex_alu_op  out  ALUOP_W  ALU operation.
- ex_use_imm  out  1  ALU B operand = immediate.
- ex_shift  out  1  ALU A operand = shamt.
- ex_use_rt  out  1  destination = rt (0: rd).
- ex_can_ovf  out  1  enable overflow trap.
- ex_fwd_a, ex_fwd_b  out  2  operand source: 00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
- ex_illegal  out  1  the ID/EX entry is an undecoded opcode/func.
- mem_branch  out  1  EX/MEM holds a valid BEQ.
- mem_write  out  1  EX/MEM holds a valid SW.
- wb_reg_write  out  1  write the regfile.
- wb_mem_to_reg  out  1  writeback data = memory.
- wb_dest  out  RA_W  writeback register.

Behaviour:
- Reset: all control registers, including the valid bits, clear to 0. All outputs are 0 (ex_alu_op = 0) while reset is high and immediately after it. Asserting reset mid-operation discards every in-flight entry.

Decode (combinational on if_id_inst; registered into ID/EX):
- Supported instructions: SPECIAL (ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLL 000000, SRL 000010, SRA 000011), ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011, BEQ 000100.
- use_imm: 1 for ADDI/ANDI/ORI/LW/SW; 0 otherwise.
- shift: 1 for SLL/SRL/SRA.
- can_ovf: 1 for ADD/SUB/ADDI.
- id_sign_ext: 1 except for ANDI/ORI.
- LW/SW use ALU ADD; BEQ uses SUB.
- Destination: rd for SPECIAL; rt for ADDI/ANDI/ORI/LW; none for SW/BEQ.
- reg_write is forced to 0 when the destination is 0.
- Sources read: rs for all instructions except shifts; rt for SPECIAL, SW and BEQ.
- Unknown opcode/func: bubble controls, ALU op = SLL, illegal flag = 1.

Pipeline:
- Each edge without stall: ID/EX <= decode(if_id_inst) qualified by if_id_valid; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
- Latency: an instruction's ex_* outputs appear 1 cycle after the edge that captures it, mem_* after 2, wb_* after 3.

Hazards:
- FWD_EN=1:
  - stall=1 when ID/EX is a valid LW with dest d≠0 and the IF/ID instruction reads d.
  - fwd = 01 if the EX/MEM entry writes the matching non-zero register; else 10 if MEM/WB does; else 00. EX/MEM has priority.
- FWD_EN=0:
  - stall=1 while the ID/EX or EX/MEM entry writes a register read by IF/ID.
  - fwd is always 00; the regfile is write-before-read, so MEM/WB is not a hazard.
- On stall: IF/ID and PC hold; ID/EX loads a bubble; EX/MEM and MEM/WB advance.

Branch:
- mem_branch & branch_taken gives flush_ifid=1 in the same cycle.
- At the next edge, ID/EX and EX/MEM load bubbles.
- Flush overrides stall (stall forced 0).
- Branch flush and load-use in the same cycle: flush wins.

Test Plan:
- Reset asserted mid-stream with 3 valid entries in flight -> all outputs 0 the same cycle; after release, 3 bubbles (wb_reg_write=0) before the first new result.
- Issue ADDI $5,$0,7 (0x20050007) -> next cycle ex_use_imm=1, ex_can_ovf=1, ex_alu_op=ALU_ADD; 3 cycles after capture, wb_reg_write=1, wb_dest=5.
- ADD $3,$1,$2 (0x00221820) followed by ADD $4,$3,$3 (0x00632020) -> second instruction gets ex_fwd_a=ex_fwd_b=01, no stall (FWD_EN=1). With FWD_EN=0: stall=1 for 2 cycles, fwd=00.
- LW $2,0($1) (0x8C220000) followed by ADD $4,$2,$2 (0x00422020) -> stall=1 for exactly 1 cycle, one bubble in ID/EX, then ex_fwd_a=ex_fwd_b=10.
- BEQ $1,$1,4 (0x10210004) reaches MEM with branch_taken=1 -> flush_ifid=1; the next two mem_write/wb_reg_write slots are 0; a coincident load-use stall is suppressed.
- Opcode 0x3F (0xFC000000) -> ex_illegal=1, ex_alu_op=ALU_SLL, and no reg_write or mem_write downstream.
